pc_stack_unit: RTL and testbench
================================

PC_STACK_UNIT -- requirements
Module: pc_stack_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter STACK_DEPTH, default 8, number of return-address entries (power of two, 2..64).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  advance enable; 0 = stall, no state change.
REQ-006 PCSrc  input  2  next-PC select from control unit: 00 PC+1, 01 jump, 10 branch taken, 11 return.
REQ-007 StackWr  input  1  push PC+1 onto return stack (call).
REQ-008 StackRd  input  1  pop return stack (return).
REQ-009 imm_j  input  26  jump immediate.
REQ-010 imm_b  input  16  signed branch offset, in words.
REQ-011 pc  output  32  current instruction address (word-addressed), registered.
REQ-012 pc_plus1  output  32  pc+1, combinational.
REQ-013 stack_top  output  32  entry at top of stack; 0 when empty.
REQ-014 stack_empty / stack_full  output  1 each  occupancy flags.
REQ-015 stack_ovf / stack_unf  output  1 each  sticky overflow / underflow error flags.

Function
REQ-016 Next PC SHALL be: 00 -> pc+1; 01 -> {pc[31:26], imm_j}; 10 -> pc + sign-extended imm_b; 11 -> stack_top.
REQ-017 All additions SHALL be 32-bit modulo 2^32; pc=32'hFFFF_FFFF with PCSrc=00 SHALL wrap to 0.
REQ-018 With en=1, pc SHALL update at the same clock edge as the stack action (latency one cycle from inputs to pc).
REQ-019 With en=0, pc, stack contents, pointer and flags SHALL hold regardless of PCSrc/StackRd/StackWr.
REQ-020 Push (StackWr=1, StackRd=0, not full) SHALL write pc+1 at the top and increment occupancy by one.
REQ-021 Pop (StackRd=1, StackWr=0, not empty) SHALL decrement occupancy by one; popped value is stack_top before the edge.
REQ-022 Push while full SHALL discard the write, leave contents unchanged, and set stack_ovf; pc SHALL still follow PCSrc.
REQ-023 Pop while empty SHALL leave occupancy at 0 and set stack_unf; if PCSrc=11, pc SHALL take pc+1 instead of stack_top.
REQ-024 PCSrc=11 without StackRd SHALL read stack_top without popping.
REQ-025 StackRd and StackWr both 1 SHALL replace the top entry with pc+1 (occupancy unchanged); on empty stack this SHALL act as a plain push, with stack_unf untouched.
REQ-026 stack_full SHALL be 1 exactly when occupancy = STACK_DEPTH; stack_empty exactly when occupancy = 0.
REQ-027 stack_ovf/stack_unf SHALL stay set until reset.

Reset
REQ-028 On reset low, asynchronously: pc=RESET_PC, occupancy=0, stack_empty=1, stack_full=0, stack_ovf=0, stack_unf=0, stack_top=0.
REQ-029 Stack storage contents SHALL need no reset; unoccupied entries SHALL never be visible on stack_top.
REQ-030 Reset asserted mid-operation SHALL abort any pending push/pop; first update after release SHALL use pc=RESET_PC.

Structure
REQ-031 PCSrc encodings (PC_INC, PC_JMP, PC_BR, PC_RET), address width 32 and STACK_DEPTH default SHALL live in the shared processor package.
REQ-032 Return stack SHALL be a sub-module return_stack (storage, pointer, full/empty, ovf/unf); next-PC mux and pc register in pc_stack_unit.

Verification
REQ-033 Reset release, en=1, PCSrc=00 for 3 cycles -> pc 0,1,2,3; pc=FFFF_FFFF + PCSrc=00 -> pc=0.
REQ-034 pc=0x0400_0010, PCSrc=01, imm_j=0x0000123 -> pc=0x0400_0123; pc=0x20, PCSrc=10, imm_b=16'hFFFC -> pc=0x1C.
REQ-035 pc=0x40, StackWr=1, PCSrc=01, imm_j=0x100 -> pc=0x100, stack_top=0x41; then StackRd=1, PCSrc=11 -> pc=0x41, stack_empty=1.
REQ-036 Nine pushes with depth 8 -> stack_full=1 after eighth, stack_ovf=1 after ninth, top still eighth value; nine pops -> stack_unf=1, pc=pc+1 on ninth.
REQ-037 en=0 with PCSrc=01 and StackWr=1 -> pc, occupancy unchanged; reset pulsed low mid-stream -> pc=RESET_PC immediately, flags cleared.

Source files
------------

// File: rtl/pc_stack_unit_pkg.sv
// Shared processor definitions: next-PC select encodings, address width and
// default return-stack depth.
package pc_stack_unit_pkg;

    localparam int unsigned ADDR_W          = 32;
    localparam int unsigned STACK_DEPTH_DEF = 8;

    typedef enum logic [1:0] {
        PC_INC = 2'b00,
        PC_JMP = 2'b01,
        PC_BR  = 2'b10,
        PC_RET = 2'b11
    } pc_src_e;

endpackage

// File: rtl/pc_stack_unit_if.sv
// Control-unit to PC/stack bus: next-PC controls in, PC and stack status out.
interface pc_stack_unit_if;
    import pc_stack_unit_pkg::*;

    logic              en;
    logic [1:0]        PCSrc;
    logic              StackWr;
    logic              StackRd;
    logic [25:0]       imm_j;
    logic [15:0]       imm_b;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus1;
    logic [ADDR_W-1:0] stack_top;
    logic              stack_empty;
    logic              stack_full;
    logic              stack_ovf;
    logic              stack_unf;

    modport master (
        output en, PCSrc, StackWr, StackRd, imm_j, imm_b,
        input  pc, pc_plus1, stack_top, stack_empty, stack_full, stack_ovf, stack_unf
    );

    modport slave (
        input  en, PCSrc, StackWr, StackRd, imm_j, imm_b,
        output pc, pc_plus1, stack_top, stack_empty, stack_full, stack_ovf, stack_unf
    );

endinterface

// File: rtl/pc_stack_unit_return_stack.sv
// Return-address stack: unreset storage, occupancy counter, full/empty and
// sticky overflow/underflow flags.
module return_stack
    import pc_stack_unit_pkg::*;
#(
    parameter int unsigned DEPTH = STACK_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] wdata,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              full,
    output logic              ovf,
    output logic              unf
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PW:0]       count;
    logic [PW-1:0]     top_idx;
    logic [PW-1:0]     wr_idx;
    logic              mem_we;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    // Low bits wrap to 0 when full, so minus one still lands on the top slot.
    assign top_idx = count[PW-1:0] - 1'b1;
    assign top     = empty ? '0 : mem[top_idx];

    // Push-and-pop replaces the top, except on an empty stack where it pushes.
    assign wr_idx = (push && pop && !empty) ? top_idx : count[PW-1:0];
    assign mem_we = en && push && (pop || !full);

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_idx] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else if (en) begin
            if (push && !pop) begin
                if (full) ovf <= 1'b1;
                else      count <= count + 1'b1;
            end else if (pop && !push) begin
                if (empty) unf <= 1'b1;
                else       count <= count - 1'b1;
            end else if (push && pop && empty) begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter with next-PC select (increment, jump, branch, return) and
// an attached return-address stack for call/return.
module pc_stack_unit
    import pc_stack_unit_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned       STACK_DEPTH = STACK_DEPTH_DEF
) (
    input logic          clk,
    input logic          reset,
    pc_stack_unit_if.slave bus
);
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] top;
    logic              empty;
    logic              pop_empty;

    assign pc_inc    = pc_q + 1'b1;
    assign pop_empty = bus.StackRd && !bus.StackWr && empty;

    always_comb begin
        pc_next = pc_inc;
        case (pc_src_e'(bus.PCSrc))
            PC_INC: pc_next = pc_inc;
            PC_JMP: pc_next = {pc_q[31:26], bus.imm_j};
            PC_BR:  pc_next = pc_q + {{16{bus.imm_b[15]}}, bus.imm_b};
            PC_RET: pc_next = pop_empty ? pc_inc : top;
            default: pc_next = pc_inc;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC;
        end else if (bus.en) begin
            pc_q <= pc_next;
        end
    end

    return_stack #(
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .reset (reset),
        .en    (bus.en),
        .push  (bus.StackWr),
        .pop   (bus.StackRd),
        .wdata (pc_inc),
        .top   (top),
        .empty (empty),
        .full  (bus.stack_full),
        .ovf   (bus.stack_ovf),
        .unf   (bus.stack_unf)
    );

    assign bus.pc          = pc_q;
    assign bus.pc_plus1    = pc_inc;
    assign bus.stack_top   = top;
    assign bus.stack_empty = empty;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Self-checking bench for pc_stack_unit: directed scenarios plus random
// traffic, compared against a queue-based behavioural model.
module tb_pc_stack_unit;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int unsigned DEPTH  = 8;

    logic clk;
    logic reset;
    pc_stack_unit_if bus();

    pc_stack_unit #(
        .RESET_PC    (RST_PC),
        .STACK_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_stk [$];
    logic        m_ovf;
    logic        m_unf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] m_top();
        return (m_stk.size() == 0) ? 32'h0 : m_stk[$];
    endfunction

    task automatic model_reset();
        m_pc = RST_PC;
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},    bus.pc,                 m_pc);
        check({tag, ".pc1"},   bus.pc_plus1,           m_pc + 32'd1);
        check({tag, ".top"},   bus.stack_top,          m_top());
        check({tag, ".empty"}, 32'(bus.stack_empty),   32'(m_stk.size() == 0));
        check({tag, ".full"},  32'(bus.stack_full),    32'(m_stk.size() == DEPTH));
        check({tag, ".ovf"},   32'(bus.stack_ovf),     32'(m_ovf));
        check({tag, ".unf"},   32'(bus.stack_unf),     32'(m_unf));
    endtask

    // Apply one cycle of inputs, advance the model, then compare everything.
    task automatic step(input string tag, input logic en, input logic [1:0] src,
                        input logic wr, input logic rd,
                        input logic [25:0] ij, input logic [15:0] ib);
        logic [31:0] nxt;
        logic [31:0] inc;
        bus.en = en; bus.PCSrc = src; bus.StackWr = wr; bus.StackRd = rd;
        bus.imm_j = ij; bus.imm_b = ib;
        inc = m_pc + 32'd1;
        nxt = inc;
        if (en) begin
            case (src)
                2'd0: nxt = inc;
                2'd1: nxt = (m_pc & 32'hFC00_0000) | 32'(ij);
                2'd2: nxt = m_pc + 32'($signed(ib));
                2'd3: nxt = (rd && !wr && m_stk.size() == 0) ? inc : m_top();
            endcase
            if (wr && !rd) begin
                if (m_stk.size() == DEPTH) m_ovf = 1'b1;
                else m_stk.push_back(inc);
            end else if (rd && !wr) begin
                if (m_stk.size() == 0) m_unf = 1'b1;
                else void'(m_stk.pop_back());
            end else if (rd && wr) begin
                if (m_stk.size() == 0) m_stk.push_back(inc);
                else m_stk[m_stk.size()-1] = inc;
            end
            m_pc = nxt;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic pulse_reset(input string tag);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check({tag, ".pc_async"}, bus.pc, RST_PC);
        check_all(tag);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [31:0] eighth;
        logic [31:0] prev_pc;
        logic [31:0] held_pc;

        bus.en = 1'b0; bus.PCSrc = 2'd0; bus.StackWr = 1'b0; bus.StackRd = 1'b0;
        bus.imm_j = '0; bus.imm_b = '0;
        reset = 1'b0;
        model_reset();
        #12;
        check_all("rst");
        @(negedge clk);
        reset = 1'b1;

        // Sequential increment and wrap
        step("inc1", 1, 2'd0, 0, 0, '0, '0); check("inc1.lit", bus.pc, 32'd1);
        step("inc2", 1, 2'd0, 0, 0, '0, '0); check("inc2.lit", bus.pc, 32'd2);
        step("inc3", 1, 2'd0, 0, 0, '0, '0); check("inc3.lit", bus.pc, 32'd3);
        step("br_neg", 1, 2'd2, 0, 0, '0, 16'hFFFC); check("br_neg.lit", bus.pc, 32'hFFFF_FFFF);
        step("wrap", 1, 2'd0, 0, 0, '0, '0); check("wrap.lit", bus.pc, 32'h0);

        // Jump and backward branch
        step("j20", 1, 2'd1, 0, 0, 26'h20, '0);
        step("br1c", 1, 2'd2, 0, 0, '0, 16'hFFFC); check("br1c.lit", bus.pc, 32'h1C);

        // Call then return
        step("j40", 1, 2'd1, 0, 0, 26'h40, '0);
        step("call", 1, 2'd1, 1, 0, 26'h100, '0);
        check("call.pc", bus.pc, 32'h100);
        check("call.top", bus.stack_top, 32'h41);
        step("ret", 1, 2'd3, 0, 1, '0, '0);
        check("ret.pc", bus.pc, 32'h41);
        check("ret.empty", 32'(bus.stack_empty), 32'd1);

        // Jump keeps pc[31:26]
        step("jmax", 1, 2'd1, 0, 0, 26'h3FF_FFFF, '0);
        step("cross", 1, 2'd0, 0, 0, '0, '0);
        step("br10", 1, 2'd2, 0, 0, '0, 16'h0010); check("br10.lit", bus.pc, 32'h0400_0010);
        step("j123", 1, 2'd1, 0, 0, 26'h123, '0); check("j123.lit", bus.pc, 32'h0400_0123);

        // Fill, overflow, drain, underflow
        eighth = '0;
        for (int unsigned i = 0; i < 9; i++) begin
            if (i == 7) eighth = bus.pc + 32'd1;
            step("push", 1, 2'd0, 1, 0, '0, '0);
            if (i == 7) check("full8", 32'(bus.stack_full), 32'd1);
            if (i == 6) check("notfull7", 32'(bus.stack_full), 32'd0);
        end
        check("ovf9", 32'(bus.stack_ovf), 32'd1);
        check("top8", bus.stack_top, eighth);
        for (int unsigned i = 0; i < 9; i++) begin
            prev_pc = bus.pc;
            step("pop", 1, 2'd3, 0, 1, '0, '0);
            if (i == 0) check("pop1.pc", bus.pc, eighth);
            if (i == 8) begin
                check("unf9", 32'(bus.stack_unf), 32'd1);
                check("pop9.pc", bus.pc, prev_pc + 32'd1);
            end
        end

        // Read top without popping, then replace-top
        step("p1", 1, 2'd0, 1, 0, '0, '0);
        step("peek", 1, 2'd3, 0, 0, '0, '0);
        step("repl", 1, 2'd0, 1, 1, '0, '0);

        // Stall holds everything
        held_pc = bus.pc;
        step("stall", 0, 2'd1, 1, 0, 26'h55, '0);
        check("stall.pc", bus.pc, held_pc);
        step("stall2", 0, 2'd3, 0, 1, '0, '0);

        pulse_reset("midrst");
        step("post_rst", 1, 2'd0, 0, 0, '0, '0);
        check("post_rst.lit", bus.pc, RST_PC + 32'd1);

        // Random traffic
        for (int unsigned i = 0; i < 400; i++) begin
            step("rnd", ($urandom % 8) != 0, 2'($urandom_range(0, 3)),
                 ($urandom % 3) == 0, ($urandom % 3) == 0,
                 26'($urandom), 16'($urandom));
            if (i == 200) pulse_reset("rnd_rst");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
